// File: rtl/gf409_pkg.sv
// Shared constants and FSM encoding for the GF(2^409) partial-product accumulate/reduce block.
package gf409_pkg;
   localparam int DIGIT_W = 52;
   localparam int NDIG    = 8;
   localparam int M       = 409;
   localparam int K       = 87;
   localparam int PP_W    = 2 * DIGIT_W - 1;
   localparam int IDX_W   = 4;
   localparam int ACC_W   = (2 * NDIG - 2) * DIGIT_W + PP_W;
   localparam int IDX_MAX = 2 * NDIG - 2;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      RED1  = 2'd1,
      RED2  = 2'd2,
      DONE  = 2'd3
   } state_e;
endpackage

// File: rtl/gf409_fold.sv
// One trinomial fold modulo x^409+x^87+1: bits at and above x^409 are folded back onto x^0 and x^87.
module gf409_fold
   import gf409_pkg::*;
(
   input  logic [ACC_W-1:0] acc,
   output logic [ACC_W-1:0] folded
);
   logic [ACC_W-M-1:0] hi_s;
   logic [ACC_W-1:0]   hi_wide_s;

   assign hi_s      = acc[ACC_W-1:M];
   assign hi_wide_s = {{M{1'b0}}, hi_s};
   // hi<<K tops out at degree 508, so nothing is lost off the top of the accumulator.
   assign folded    = {{(ACC_W-M){1'b0}}, acc[M-1:0]} ^ hi_wide_s ^ (hi_wide_s << K);
endmodule

// File: rtl/gf409_pp_accum_reduce.sv
// XOR-accumulates 103-bit partial products at digit offsets into an 831-bit register,
// then folds twice modulo x^409+x^87+1 and presents the 409-bit field element.
module gf409_pp_accum_reduce
   import gf409_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              pp_valid,
   output logic              pp_ready,
   input  logic [PP_W-1:0]   pp_data,
   input  logic [IDX_W-1:0]  pp_idx,
   input  logic              pp_last,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [M-1:0]      res_data,
   output logic              idx_err
);
   state_e             state_r;
   state_e             state_nx_s;
   logic [ACC_W-1:0]   acc_r;
   logic [ACC_W-1:0]   ins_s;
   logic [ACC_W-1:0]   fold_s;
   logic               idx_err_r;
   logic               beat_s;
   logic               take_s;
   logic               idx_bad_s;

   assign beat_s    = pp_valid & pp_ready;
   assign take_s    = res_valid & res_ready;
   assign idx_bad_s = (pp_idx > IDX_W'(IDX_MAX));
   assign idx_err   = idx_err_r;

   gf409_fold u_fold (
      .acc    (acc_r),
      .folded (fold_s)
   );

   // Offset insertion: one-hot select of the digit slot; out-of-range indices insert nothing.
   always_comb begin
      ins_s = {ACC_W{1'b0}};
      for (int s = 0; s <= IDX_MAX; s++) begin
         ins_s[s*DIGIT_W +: PP_W] = ins_s[s*DIGIT_W +: PP_W]
                                  | ((pp_idx == IDX_W'(s)) ? pp_data : {PP_W{1'b0}});
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ACCUM;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic: always exactly two folds between the last beat and the result.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ACCUM: begin
            if (beat_s && pp_last) begin
               state_nx_s = RED1;
            end else begin
               state_nx_s = ACCUM;
            end
         end
         RED1: state_nx_s = RED2;
         RED2: state_nx_s = DONE;
         DONE: begin
            if (take_s) begin
               state_nx_s = ACCUM;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: state_nx_s = ACCUM;
      endcase
   end

   // Moore outputs decoded from the registered state; result is masked outside DONE.
   always_comb begin
      pp_ready  = 1'b0;
      res_valid = 1'b0;
      res_data  = {M{1'b0}};
      case (state_r)
         ACCUM: pp_ready = 1'b1;
         RED1:  pp_ready = 1'b0;
         RED2:  pp_ready = 1'b0;
         DONE: begin
            res_valid = 1'b1;
            res_data  = acc_r[M-1:0];
         end
         default: pp_ready = 1'b0;
      endcase
   end

   // Accumulator and sticky index error; both clear when a result is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r     <= {ACC_W{1'b0}};
         idx_err_r <= 1'b0;
      end else begin
         case (state_r)
            ACCUM: begin
               if (beat_s) begin
                  acc_r <= acc_r ^ ins_s;
                  if (idx_bad_s) begin
                     idx_err_r <= 1'b1;
                  end
               end
            end
            RED1: acc_r <= fold_s;
            RED2: acc_r <= fold_s;
            DONE: begin
               if (take_s) begin
                  acc_r     <= {ACC_W{1'b0}};
                  idx_err_r <= 1'b0;
               end
            end
            default: acc_r <= {ACC_W{1'b0}};
         endcase
      end
   end
endmodule

// File: tb/tb_gf409_pp_accum_reduce.sv
// Directed self-checking bench for gf409_pp_accum_reduce with hand-computed field results.
module tb_gf409_pp_accum_reduce;
   logic          clk = 1'b0;
   logic          rst;
   logic          pp_valid;
   logic          pp_ready;
   logic [102:0]  pp_data;
   logic [3:0]    pp_idx;
   logic          pp_last;
   logic          res_valid;
   logic          res_ready;
   logic [408:0]  res_data;
   logic          idx_err;

   int n_total = 0;
   int n_bad   = 0;

   gf409_pp_accum_reduce dut (
      .clk       (clk),
      .rst       (rst),
      .pp_valid  (pp_valid),
      .pp_ready  (pp_ready),
      .pp_data   (pp_data),
      .pp_idx    (pp_idx),
      .pp_last   (pp_last),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .idx_err   (idx_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [408:0] got, input logic [408:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drives one beat from posedge+1, lets one edge take it, returns at posedge+1.
   task automatic beat(input logic [3:0] idx, input logic [102:0] d, input logic last);
      pp_valid = 1'b1;
      pp_idx   = idx;
      pp_data  = d;
      pp_last  = last;
      @(posedge clk);
      #1;
      pp_valid = 1'b0;
      pp_last  = 1'b0;
      pp_data  = 103'd0;
      pp_idx   = 4'd0;
   endtask

   // Waits (bounded) for res_valid after a last beat and checks latency, data and idx_err.
   task automatic expect_res(input string tag, input logic [408:0] exp, input logic exp_err);
      int n;
      n = 0;
      while (!res_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_lat"}, 409'(n), 409'd2);
      check({tag, "_data"}, res_data, exp);
      check({tag, "_err"}, 409'(idx_err), 409'(exp_err));
   endtask

   task automatic accept(input string tag);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      pp_valid  = 1'b0;
      pp_last   = 1'b0;
      check({tag, "_rv_low"}, 409'(res_valid), 409'd0);
      check({tag, "_rd_zero"}, res_data, 409'd0);
   endtask

   logic [408:0] e;
   logic [102:0] d;

   initial begin
      rst       = 1'b1;
      pp_valid  = 1'b0;
      pp_data   = 103'd0;
      pp_idx    = 4'd0;
      pp_last   = 1'b0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_pp_ready", 409'(pp_ready), 409'd1);
      check("rst_res_valid", 409'(res_valid), 409'd0);
      check("rst_res_data", res_data, 409'd0);
      check("rst_idx_err", 409'(idx_err), 409'd0);

      // Single unit beat.
      beat(4'd0, 103'd1, 1'b1);
      check("t1_busy", 409'(pp_ready), 409'd0);
      expect_res("t1", 409'd1, 1'b0);
      accept("t1");

      // x^409 folds to x^87 + 1.
      d = 103'd1 << 45;
      beat(4'd7, d, 1'b1);
      e = 409'd0; e[87] = 1'b1; e[0] = 1'b1;
      expect_res("t2", e, 1'b0);
      accept("t2");

      // x^816 needs both folds: x^407 + x^172 + x^85.
      d = 103'd1 << 88;
      beat(4'd14, d, 1'b1);
      e = 409'd0; e[407] = 1'b1; e[172] = 1'b1; e[85] = 1'b1;
      expect_res("t3", e, 1'b0);
      accept("t3");

      // Identical beats cancel.
      beat(4'd3, 103'h5A5A, 1'b0);
      beat(4'd3, 103'h5A5A, 1'b0);
      beat(4'd0, 103'd0, 1'b1);
      expect_res("t4", 409'd0, 1'b0);
      accept("t4");

      // Overlapping slots cancel at x^60; disjoint ones land at 52*s.
      beat(4'd0, 103'd1 << 60, 1'b0);
      beat(4'd1, 103'd1 << 8, 1'b1);
      expect_res("t5a", 409'd0, 1'b0);
      accept("t5a");
      beat(4'd1, 103'd1 << 100, 1'b0);
      beat(4'd2, 103'd1, 1'b1);
      e = 409'd0; e[152] = 1'b1; e[104] = 1'b1;
      expect_res("t5b", e, 1'b0);
      accept("t5b");

      // Backpressure in DONE: result held, offered beats ignored.
      beat(4'd1, 103'd3, 1'b1);
      e = 409'd0; e[52] = 1'b1; e[53] = 1'b1;
      expect_res("t6", e, 1'b0);
      pp_valid = 1'b1; pp_idx = 4'd0; pp_data = {103{1'b1}}; pp_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("t6_hold_data", res_data, e);
         check("t6_hold_ready", 409'(pp_ready), 409'd0);
      end
      accept("t6");
      pp_data = 103'd0; pp_idx = 4'd0;
      beat(4'd0, 103'd1, 1'b1);
      expect_res("t6_clean", 409'd1, 1'b0);
      accept("t6_clean");

      // Out-of-range index: data dropped, sticky error until result taken.
      beat(4'd15, {103{1'b1}}, 1'b0);
      check("t7_err_early", 409'(idx_err), 409'd1);
      beat(4'd0, 103'd1, 1'b1);
      expect_res("t7", 409'd1, 1'b1);
      accept("t7");
      check("t7_err_clr", 409'(idx_err), 409'd0);

      // Reset mid-operation discards partial accumulation and error.
      beat(4'd2, 103'hFF, 1'b0);
      beat(4'd15, 103'd5, 1'b0);
      beat(4'd9, 103'd7, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t8_ready", 409'(pp_ready), 409'd1);
      check("t8_err", 409'(idx_err), 409'd0);
      beat(4'd0, 103'd1, 1'b1);
      expect_res("t8", 409'd1, 1'b0);
      accept("t8");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
